// File: rtl/fetch_debug_ctrl.sv
// Host-command sequencer feeding the fetch stage: program load, run/step, halt.
// Optional cycle counter enabled by defining FETCH_DEBUG_CYCLE_COUNT_EN.
module fetch_debug_ctrl #(
   parameter int                 NB_BITS    = 32,
   parameter int                 RAM_DEPTH  = 10,
   parameter logic [NB_BITS-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [7:0]           i_rx_data,
   input  logic                 i_rx_valid,
   input  logic [NB_BITS-1:0]   i_instr,
   output logic                 o_debug,
   output logic                 o_step,
   output logic                 o_wren_debug,
   output logic [NB_BITS-1:0]   o_data_debug,
   output logic [RAM_DEPTH-1:0] o_addr_debug,
   output logic                 o_pipe_rst,
   output logic [2:0]           o_state,
   output logic                 o_halted,
   output logic                 o_load_ovf,
   output logic [31:0]          o_cycles
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RUN    = 3'd2,
      STEP   = 3'd3,
      HALTED = 3'd4
   } state_t;

   localparam logic [7:0] CMD_L = 8'h4C;
   localparam logic [7:0] CMD_R = 8'h52;
   localparam logic [7:0] CMD_S = 8'h53;
   localparam logic [7:0] CMD_N = 8'h4E;
   localparam logic [7:0] CMD_Q = 8'h51;
   localparam logic [7:0] CMD_C = 8'h43;

   state_t             state;
   logic [NB_BITS-9:0] shreg;
   logic [1:0]         byte_cnt;
   logic               halt_hit;
   logic               addr_top;
   logic               rx_n;
   logic               rx_q;
   logic               rx_c;

   assign halt_hit = (i_instr == HALT_INSTR);
   assign addr_top = &o_addr_debug;
   assign rx_n     = i_rx_valid && (i_rx_data == CMD_N);
   assign rx_q     = i_rx_valid && (i_rx_data == CMD_Q);
   assign rx_c     = i_rx_valid && (i_rx_data == CMD_C);

   // A halt seen while running drops fetch back into debug in that same cycle.
   assign o_debug = (state != RUN) || halt_hit;
   assign o_state = state;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= IDLE;
         shreg        <= '0;
         byte_cnt     <= '0;
         o_step       <= 1'b0;
         o_wren_debug <= 1'b0;
         o_data_debug <= '0;
         o_addr_debug <= '0;
         o_pipe_rst   <= 1'b0;
         o_halted     <= 1'b0;
         o_load_ovf   <= 1'b0;
      end else begin
         o_step       <= 1'b0;
         o_wren_debug <= 1'b0;
         o_pipe_rst   <= 1'b0;
         case (state)
            IDLE: begin
               if (i_rx_valid) begin
                  case (i_rx_data)
                     CMD_L: begin
                        state        <= LOAD;
                        o_addr_debug <= '0;
                        byte_cnt     <= '0;
                        o_load_ovf   <= 1'b0;
                     end
                     CMD_R:   state <= RUN;
                     CMD_S:   state <= STEP;
                     default: state <= IDLE;
                  endcase
               end
            end
            LOAD: begin
               if (i_rx_valid) begin
                  shreg    <= {shreg[NB_BITS-17:0], i_rx_data};
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     o_wren_debug <= 1'b1;
                     o_data_debug <= {shreg, i_rx_data};
                  end
               end
               // Post-write bookkeeping; the address never wraps past the top.
               if (o_wren_debug) begin
                  if (o_data_debug == HALT_INSTR) begin
                     state <= IDLE;
                     if (!addr_top)
                        o_addr_debug <= o_addr_debug + 1'b1;
                  end else if (addr_top) begin
                     o_load_ovf <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     o_addr_debug <= o_addr_debug + 1'b1;
                  end
               end
            end
            RUN: begin
               if (halt_hit) begin
                  state    <= HALTED;
                  o_halted <= 1'b1;
               end
            end
            STEP: begin
               if (halt_hit) begin
                  state    <= HALTED;
                  o_halted <= 1'b1;
               end else if (rx_n) begin
                  o_step <= 1'b1;
               end else if (rx_q) begin
                  state <= IDLE;
               end
            end
            HALTED: begin
               if (rx_c) begin
                  o_pipe_rst <= 1'b1;
                  o_halted   <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FETCH_DEBUG_CYCLE_COUNT_EN
   logic [31:0] cyc;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         cyc <= '0;
      else if (state == HALTED && rx_c)
         cyc <= '0;
      else if (state == RUN && !halt_hit)
         cyc <= cyc + 32'd1;
      else if (state == STEP && !halt_hit && rx_n)
         cyc <= cyc + 32'd1;
   end

   assign o_cycles = cyc;
`else
   assign o_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_debug_ctrl.sv
// Directed bench for fetch_debug_ctrl with a write scoreboard.
// Second instance uses a 4-word RAM to exercise load overflow.
module tb_fetch_debug_ctrl;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
`ifdef FETCH_DEBUG_CYCLE_COUNT_EN
   localparam bit CYC_EN = 1'b1;
`else
   localparam bit CYC_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_valid2;
   logic [31:0] instr;

   logic        debug, step, wren, pipe_rst, halted, ovf;
   logic [31:0] wdata, cycles;
   logic [9:0]  waddr;
   logic [2:0]  st;

   logic        debug2, step2, wren2, pipe_rst2, halted2, ovf2;
   logic [31:0] wdata2, cycles2;
   logic [1:0]  waddr2;
   logic [2:0]  st2;

   int errs   = 0;
   int checks = 0;

   logic [41:0] exp_q[$];
   logic [41:0] obs_q[$];
   logic [41:0] exp2_q[$];
   logic [41:0] obs2_q[$];
   int  wren_dbl = 0;
   int  step_cnt = 0;
   int  step_dbl = 0;
   logic wren_prev = 1'b0;
   logic step_prev = 1'b0;

   always #5 clk = ~clk;

   fetch_debug_ctrl dut (
      .i_clk(clk), .i_rst(rst),
      .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .i_instr(instr),
      .o_debug(debug), .o_step(step),
      .o_wren_debug(wren), .o_data_debug(wdata),
      .o_addr_debug(waddr), .o_pipe_rst(pipe_rst),
      .o_state(st), .o_halted(halted),
      .o_load_ovf(ovf), .o_cycles(cycles)
   );

   fetch_debug_ctrl #(.RAM_DEPTH(2)) dut2 (
      .i_clk(clk), .i_rst(rst),
      .i_rx_data(rx_data), .i_rx_valid(rx_valid2),
      .i_instr(instr),
      .o_debug(debug2), .o_step(step2),
      .o_wren_debug(wren2), .o_data_debug(wdata2),
      .o_addr_debug(waddr2), .o_pipe_rst(pipe_rst2),
      .o_state(st2), .o_halted(halted2),
      .o_load_ovf(ovf2), .o_cycles(cycles2)
   );

   always @(negedge clk) begin
      if (wren) obs_q.push_back({waddr, wdata});
      if (wren2) obs2_q.push_back({8'h00, waddr2, wdata2});
      if (wren && wren_prev) wren_dbl++;
      if (step) step_cnt++;
      if (step && step_prev) step_dbl++;
      wren_prev = wren;
      step_prev = step;
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input bit to2, input bit hlt);
      @(posedge clk); #1;
      rx_data = b;
      if (to2) rx_valid2 = 1'b1;
      else rx_valid = 1'b1;
      if (hlt) instr = HALT;
      @(posedge clk); #1;
      rx_valid  = 1'b0;
      rx_valid2 = 1'b0;
      instr     = '0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit to2);
      for (int k = 0; k < 4; k++) send(w[31-8*k -: 8], to2, 1'b0);
   endtask

   task automatic drain(input string tag);
      check({tag, "_cnt"}, 64'(obs_q.size()), 64'(exp_q.size()));
      while (exp_q.size() > 0 && obs_q.size() > 0)
         check(tag, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic drain2(input string tag);
      check({tag, "_cnt"}, 64'(obs2_q.size()), 64'(exp2_q.size()));
      while (exp2_q.size() > 0 && obs2_q.size() > 0)
         check(tag, 64'(obs2_q.pop_front()), 64'(exp2_q.pop_front()));
      exp2_q.delete();
      obs2_q.delete();
   endtask

   initial begin
      logic [31:0] words[4];
      int          base;

      rst = 1'b1; rx_data = '0; rx_valid = 1'b0;
      rx_valid2 = 1'b0; instr = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", st, 0);
      check("rst_debug", debug, 1);
      check("rst_wren", wren, 0);
      check("rst_addr", waddr, 0);
      check("rst_data", wdata, 0);
      check("rst_pipe", pipe_rst, 0);
      check("rst_halted", halted, 0);
      check("rst_ovf", ovf, 0);
      check("rst_step", step, 0);
      check("rst_cycles", cycles, 0);
      rst = 1'b0;

      send("Z", 1'b0, 1'b0);
      check("unknown_idle", st, 0);

      // Basic load: data word, then the HALT word ends the load.
      send("L", 1'b0, 1'b0);
      check("load_state", st, 1);
      send_word(32'h0000_0020, 1'b0);
      exp_q.push_back({10'd0, 32'h0000_0020});
      check("load_mid_state", st, 1);
      send_word(HALT, 1'b0);
      exp_q.push_back({10'd1, HALT});
      repeat (2) @(posedge clk);
      #1;
      check("load_end_state", st, 0);
      check("load_ovf", ovf, 0);
      check("load_debug", debug, 1);
      drain("load_wr");

      // Overflow on the 4-word instance.
      words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4C52_534E};
      send("L", 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         send_word(words[i], 1'b1);
         exp2_q.push_back({8'h00, 2'(i), words[i]});
      end
      repeat (2) @(posedge clk);
      #1;
      check("ovf_flag", ovf2, 1);
      check("ovf_state", st2, 0);
      check("ovf_addr", waddr2, 3);
      drain2("ovf_wr");

      // Reset mid-word, then reload cleanly.
      send("L", 1'b0, 1'b0);
      send(8'hAA, 1'b0, 1'b0);
      send(8'hBB, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_state", st, 0);
      check("abort_addr", waddr, 0);
      check("abort_wren", wren, 0);
      send("L", 1'b0, 1'b0);
      send_word(32'h1234_5678, 1'b0);
      exp_q.push_back({10'd0, 32'h1234_5678});
      send_word(HALT, 1'b0);
      exp_q.push_back({10'd1, HALT});
      repeat (2) @(posedge clk);
      #1;
      check("reload_state", st, 0);
      drain("reload_wr");

      // Free run, HALT arrives on the 5th RUN cycle.
      send("R", 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("run_debug", debug, 0);
         check("run_state", st, 2);
         @(posedge clk); #1;
      end
      instr = HALT;
      #1;
      check("halt_debug_same", debug, 1);
      @(posedge clk); #1;
      instr = '0;
      check("halt_state", st, 4);
      check("halt_flag", halted, 1);
      check("halt_cycles", cycles, CYC_EN ? 4 : 0);

      send("X", 1'b0, 1'b0);
      check("halt_x_state", st, 4);
      check("halt_x_pipe", pipe_rst, 0);
      send("C", 1'b0, 1'b0);
      check("clr_pipe", pipe_rst, 1);
      check("clr_state", st, 0);
      check("clr_halted", halted, 0);
      check("clr_cycles", cycles, 0);
      @(posedge clk); #1;
      check("clr_pipe_end", pipe_rst, 0);

      // Single-step.
      base = step_cnt;
      send("S", 1'b0, 1'b0);
      check("step_state", st, 3);
      send("N", 1'b0, 1'b0);
      check("step_pulse", step, 1);
      check("step_debug", debug, 1);
      @(posedge clk); #1;
      check("step_pulse_end", step, 0);
      send("N", 1'b0, 1'b0);
      send("Q", 1'b0, 1'b0);
      check("step_quit", st, 0);
      check("step_count", step_cnt - base, 2);
      check("step_cycles", cycles, CYC_EN ? 2 : 0);

      // HALT beats a simultaneous 'N'.
      base = step_cnt;
      send("S", 1'b0, 1'b0);
      send("N", 1'b0, 1'b1);
      check("stephalt_state", st, 4);
      check("stephalt_step", step, 0);
      @(posedge clk); #1;
      check("stephalt_count", step_cnt - base, 0);
      check("stephalt_cycles", cycles, CYC_EN ? 2 : 0);
      send("C", 1'b0, 1'b0);
      check("stephalt_clr", st, 0);

      check("wren_single", wren_dbl, 0);
      check("step_single", step_dbl, 0);
      check("spurious_wr", obs_q.size() + obs2_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
